// File: rtl/punc_debug_dumper.sv
// Debug dumper: streams the PC, the register file and a memory window out over a
// valid/ready port. Each word uses one SETTLE cycle for the debug read and one or more SEND cycles.
module punc_debug_dumper #(
    parameter int NUM_RF = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] mem_base_i,
    input  logic [15:0] mem_count_i,
    output logic [15:0] mem_debug_addr_o,
    output logic [2:0]  rf_debug_addr_o,
    input  logic [15:0] mem_debug_data_i,
    input  logic [15:0] rf_debug_data_i,
    input  logic [15:0] pc_debug_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] out_data_o,
    output logic [1:0]  out_tag_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {IDLE, SETTLE, SEND, FINISH} state_t;
    typedef enum logic [1:0] {PHASE_PC = 2'd0, PHASE_RF = 2'd1, PHASE_MEM = 2'd2} phase_t;

    localparam logic [15:0] LastRf = 16'(NUM_RF - 1);

    state_t      state_q;
    phase_t      phase_q;
    phase_t      phase_d;
    logic [15:0] index_q;
    logic [15:0] index_d;
    logic [15:0] memBase_q;
    logic [15:0] memCount_q;
    logic        lastItem;
    logic [15:0] selData;

    assign busy_o = (state_q != IDLE);

    // Successor of the current item; lastItem marks the final word of the dump.
    always_comb begin
        phase_d  = phase_q;
        index_d  = index_q;
        lastItem = 1'b0;
        unique case (phase_q)
            PHASE_PC: begin
                phase_d = PHASE_RF;
                index_d = 16'd0;
            end
            PHASE_RF: begin
                if (index_q == LastRf) begin
                    if (memCount_q == 16'd0) begin
                        lastItem = 1'b1;
                    end else begin
                        phase_d = PHASE_MEM;
                        index_d = 16'd0;
                    end
                end else begin
                    index_d = index_q + 16'd1;
                end
            end
            PHASE_MEM: begin
                if (index_q == memCount_q - 16'd1) begin
                    lastItem = 1'b1;
                end else begin
                    index_d = index_q + 16'd1;
                end
            end
            default: lastItem = 1'b1;
        endcase
    end

    always_comb begin
        selData = pc_debug_data_i;
        unique case (phase_q)
            PHASE_RF:  selData = rf_debug_data_i;
            PHASE_MEM: selData = mem_debug_data_i;
            default:   selData = pc_debug_data_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            phase_q          <= PHASE_PC;
            index_q          <= 16'd0;
            memBase_q        <= 16'd0;
            memCount_q       <= 16'd0;
            mem_debug_addr_o <= 16'd0;
            rf_debug_addr_o  <= 3'd0;
            out_valid_o      <= 1'b0;
            out_data_o       <= 16'd0;
            out_tag_o        <= 2'd0;
            done_o           <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    out_valid_o <= 1'b0;
                    done_o      <= 1'b0;
                    if (start_i) begin
                        memBase_q  <= mem_base_i;
                        memCount_q <= mem_count_i;
                        phase_q    <= PHASE_PC;
                        index_q    <= 16'd0;
                        state_q    <= SETTLE;
                    end
                end
                SETTLE: begin
                    out_data_o  <= selData;
                    out_tag_o   <= phase_q;
                    out_valid_o <= 1'b1;
                    state_q     <= SEND;
                end
                SEND: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        if (lastItem) begin
                            done_o  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            phase_q <= phase_d;
                            index_q <= index_d;
                            // Debug addresses move only when their own phase needs a new item.
                            if (phase_d == PHASE_MEM) begin
                                mem_debug_addr_o <= memBase_q + index_d;
                            end
                            if (phase_d == PHASE_RF) begin
                                rf_debug_addr_o <= index_d[2:0];
                            end
                            state_q <= SETTLE;
                        end
                    end
                end
                FINISH: begin
                    done_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_punc_debug_dumper.sv
// Directed bench for punc_debug_dumper with a small processor debug-port model.
module tb_punc_debug_dumper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] memBase;
    logic [15:0] memCount;
    logic [15:0] memDebugAddr;
    logic [2:0]  rfDebugAddr;
    logic [15:0] memDebugData;
    logic [15:0] rfDebugData;
    logic [15:0] pcDebugData;
    logic        outValid;
    logic        outReady;
    logic [15:0] outData;
    logic [1:0]  outTag;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int doneCount = 0;
    int doneBefore;

    logic [15:0] basicMem [3] = '{16'h000A, 16'h000B, 16'h000C};
    logic [15:0] wrapAddr [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    logic [15:0] wrapData [4] = '{16'h5A5B, 16'h5A5A, 16'hA5A5, 16'hA5A4};

    always #5 clk = ~clk;

    punc_debug_dumper #(.NUM_RF(8)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .mem_base_i       (memBase),
        .mem_count_i      (memCount),
        .mem_debug_addr_o (memDebugAddr),
        .rf_debug_addr_o  (rfDebugAddr),
        .mem_debug_data_i (memDebugData),
        .rf_debug_data_i  (rfDebugData),
        .pc_debug_data_i  (pcDebugData),
        .out_valid_o      (outValid),
        .out_ready_i      (outReady),
        .out_data_o       (outData),
        .out_tag_o        (outTag),
        .busy_o           (busy),
        .done_o           (done)
    );

    // Processor debug ports: fixed PC, R[n]=0x10+n, memory 0x4000..0x4002 = A,B,C, else addr^0xA5A5.
    always_comb begin
        pcDebugData = 16'h3000;
        rfDebugData = 16'h0010 + 16'(rfDebugAddr);
        if (memDebugAddr >= 16'h4000 && memDebugAddr <= 16'h4002) begin
            memDebugData = 16'h000A + (memDebugAddr - 16'h4000);
        end else begin
            memDebugData = memDebugAddr ^ 16'hA5A5;
        end
    end

    always @(posedge clk) begin
        if (done === 1'b1) doneCount <= doneCount + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout observed=running required=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string name, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] base, input logic [15:0] count);
        memBase  = base;
        memCount = count;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic doReset();
        rst   = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic collectWord(input string name, input logic [15:0] expData, input logic [1:0] expTag,
                               input logic [15:0] expMemAddr, input logic [2:0] expRf);
        int waited = 0;
        while (outValid !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (outValid !== 1'b1) checkOutput({name, "_valid_timeout"}, 16'(outValid), 16'h0001);
        checkOutput({name, "_data"}, outData, expData);
        checkOutput({name, "_tag"}, 16'(outTag), 16'(expTag));
        checkOutput({name, "_memaddr"}, memDebugAddr, expMemAddr);
        if (expTag == 2'd1) checkOutput({name, "_rfaddr"}, 16'(rfDebugAddr), 16'(expRf));
        @(negedge clk);
    endtask

    task automatic collectRegs(input int first, input logic [15:0] memAddr);
        for (int i = first; i < 8; i++) begin
            collectWord($sformatf("r%0d", i), 16'(16'h0010 + i), 2'd1, memAddr, 3'(i));
        end
    endtask

    task automatic checkDone(input string name);
        checkOutput({name, "_done_pulse"}, 16'(done), 16'h0001);
        @(negedge clk);
        checkOutput({name, "_done_clear"}, 16'(done), 16'h0000);
        checkOutput({name, "_idle_busy"}, 16'(busy), 16'h0000);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        memBase  = 16'h0;
        memCount = 16'h0;
        outReady = 1'b1;

        // Reset state, with start held during reset
        doReset();
        checkOutput("rst_valid", 16'(outValid), 16'h0000);
        checkOutput("rst_busy", 16'(busy), 16'h0000);
        checkOutput("rst_done", 16'(done), 16'h0000);
        checkOutput("rst_data", outData, 16'h0000);
        checkOutput("rst_tag", 16'(outTag), 16'h0000);
        checkOutput("rst_memaddr", memDebugAddr, 16'h0000);
        checkOutput("rst_rfaddr", 16'(rfDebugAddr), 16'h0000);

        // Basic dump: 12 words, two-cycle start latency
        $display("[TB] basic dump");
        applyStimulus(16'h4000, 16'd3);
        checkOutput("basic_settle_valid", 16'(outValid), 16'h0000);
        checkOutput("basic_settle_busy", 16'(busy), 16'h0001);
        @(negedge clk);
        checkOutput("basic_latency_valid", 16'(outValid), 16'h0001);
        collectWord("basic_pc", 16'h3000, 2'd0, 16'h0000, 3'd0);
        collectRegs(0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            collectWord($sformatf("basic_mem%0d", i), basicMem[i], 2'd2, 16'(16'h4000 + i), 3'd0);
        end
        checkDone("basic");

        // Zero count, then start in FINISH ignored and the next IDLE start accepted
        $display("[TB] zero count");
        doReset();
        applyStimulus(16'h4000, 16'd0);
        collectWord("zero_pc", 16'h3000, 2'd0, 16'h0000, 3'd0);
        collectRegs(0, 16'h0000);
        checkOutput("zero_done_pulse", 16'(done), 16'h0001);
        start = 1'b1;
        @(negedge clk);
        checkOutput("finish_start_ignored", 16'(busy), 16'h0000);
        checkOutput("finish_next_done", 16'(done), 16'h0000);
        @(negedge clk);
        start = 1'b0;
        checkOutput("idle_start_accepted", 16'(busy), 16'h0001);
        collectWord("zero2_pc", 16'h3000, 2'd0, 16'h0000, 3'd0);
        collectRegs(0, 16'h0000);
        checkDone("zero2");

        // Backpressure on R1
        $display("[TB] backpressure");
        doReset();
        applyStimulus(16'h4000, 16'd3);
        collectWord("bp_pc", 16'h3000, 2'd0, 16'h0000, 3'd0);
        collectWord("bp_r0", 16'h0010, 2'd1, 16'h0000, 3'd0);
        outReady = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_hold%0d_valid", i), 16'(outValid), 16'h0001);
            checkOutput($sformatf("bp_hold%0d_data", i), outData, 16'h0011);
            checkOutput($sformatf("bp_hold%0d_tag", i), 16'(outTag), 16'h0001);
            checkOutput($sformatf("bp_hold%0d_rfaddr", i), 16'(rfDebugAddr), 16'h0001);
            @(negedge clk);
        end
        outReady = 1'b1;
        collectRegs(1, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            collectWord($sformatf("bp_mem%0d", i), basicMem[i], 2'd2, 16'(16'h4000 + i), 3'd0);
        end
        checkDone("bp");

        // Address wrap past 0xFFFF
        $display("[TB] wrap");
        doReset();
        applyStimulus(16'hFFFE, 16'd4);
        collectWord("wrap_pc", 16'h3000, 2'd0, 16'h0000, 3'd0);
        collectRegs(0, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            collectWord($sformatf("wrap_mem%0d", i), wrapData[i], 2'd2, wrapAddr[i], 3'd0);
        end
        checkDone("wrap");

        // Start while busy is ignored
        $display("[TB] start while busy");
        doReset();
        doneBefore = doneCount;
        applyStimulus(16'h4000, 16'd3);
        collectWord("sb_pc", 16'h3000, 2'd0, 16'h0000, 3'd0);
        collectWord("sb_r0", 16'h0010, 2'd1, 16'h0000, 3'd0);
        memBase  = 16'h1234;
        memCount = 16'd7;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        collectRegs(1, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            collectWord($sformatf("sb_mem%0d", i), basicMem[i], 2'd2, 16'(16'h4000 + i), 3'd0);
        end
        checkDone("sb");
        repeat (3) @(negedge clk);
        checkOutput("sb_no_restart", 16'(busy), 16'h0000);
        checkOutput("sb_one_done", 16'(doneCount - doneBefore), 16'h0001);

        // Reset during the MEM phase
        $display("[TB] reset mid-dump");
        doReset();
        applyStimulus(16'h4000, 16'd3);
        collectWord("rm_pc", 16'h3000, 2'd0, 16'h0000, 3'd0);
        collectRegs(0, 16'h0000);
        collectWord("rm_mem0", 16'h000A, 2'd2, 16'h4000, 3'd0);
        @(negedge clk);
        checkOutput("rm_mem1_valid", 16'(outValid), 16'h0001);
        checkOutput("rm_mem1_tag", 16'(outTag), 16'h0002);
        doneBefore = doneCount;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rm_valid", 16'(outValid), 16'h0000);
        checkOutput("rm_busy", 16'(busy), 16'h0000);
        checkOutput("rm_done", 16'(done), 16'h0000);
        checkOutput("rm_memaddr", memDebugAddr, 16'h0000);
        repeat (3) @(negedge clk);
        checkOutput("rm_no_done", 16'(doneCount - doneBefore), 16'h0000);
        applyStimulus(16'h4000, 16'd3);
        collectWord("rm_restart_pc", 16'h3000, 2'd0, 16'h0000, 3'd0);
        collectWord("rm_restart_r0", 16'h0010, 2'd1, 16'h0000, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
